fpu_csr_state: RTL and testbench



---
 rtl/fpu_types_pkg.sv | 20 ++
 rtl/fpu_csr_rsp_buf.sv | 31 +++
 rtl/fpu_csr_state.sv | 124 ++++++++++++
 tb/tb_fpu_csr_state.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// rtl/fpu_types_pkg.sv - shared FPU CSR types, widths and CSR addresses
package fpu_types;

    localparam int DEF_FFLAGS_BITS = 5;
    localparam int DEF_FRM_BITS    = 3;

    // Bit 4 is NV, bit 0 is NX.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

endpackage

// File: rtl/fpu_csr_rsp_buf.sv
// rtl/fpu_csr_rsp_buf.sv - single-entry registered response buffer with valid/ready
module fpu_csr_rsp_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // A new entry may enter when the slot is empty or is being drained this cycle.
    assign in_ready = !out_valid | out_ready;

    // Load on accept, hold until consumed; data stays stable while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fpu_csr_state.sv
// rtl/fpu_csr_state.sv - per-warp fflags/frm state serving FPU write-backs and CSR requests
module fpu_csr_state
    import fpu_types::*;
#(
    parameter int  NUM_WARPS   = 4,
    parameter int  FFLAGS_BITS = DEF_FFLAGS_BITS,
    parameter int  FRM_BITS    = DEF_FRM_BITS,
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fpu_write_enable,
    input  logic [NW_BITS-1:0]     fpu_write_wid,
    input  logic [FFLAGS_BITS-1:0] fpu_write_fflags,
    input  logic [NW_BITS-1:0]     fpu_read_wid,
    output logic [FRM_BITS-1:0]    fpu_read_frm,
    input  logic                   csr_req_valid,
    output logic                   csr_req_ready,
    input  logic [NW_BITS-1:0]     csr_req_wid,
    input  logic [11:0]            csr_req_addr,
    input  logic                   csr_req_write,
    input  logic [31:0]            csr_req_wdata,
    output logic                   csr_rsp_valid,
    input  logic                   csr_rsp_ready,
    output logic [31:0]            csr_rsp_data,
    output logic                   csr_rsp_err
);

    logic [FFLAGS_BITS-1:0] fflags     [NUM_WARPS];
    logic [FRM_BITS-1:0]    frm        [NUM_WARPS];
    logic [FFLAGS_BITS-1:0] fflags_nxt [NUM_WARPS];
    logic [FRM_BITS-1:0]    frm_nxt    [NUM_WARPS];

    logic                   pend_valid;
    logic [NW_BITS-1:0]     pend_wid;
    logic [FFLAGS_BITS-1:0] pend_fflags;

    logic                   hit_ff, hit_frm, hit_fcsr, wid_ok, supported;
    logic                   pend_hit_req, accept, wr_fire;
    logic [FFLAGS_BITS-1:0] pend_fwd, eff_fflags;
    logic [FRM_BITS-1:0]    cur_frm;
    logic [31:0]            rd_data;
    logic                   unused_wdata;

    assign unused_wdata = ^csr_req_wdata[31:FFLAGS_BITS+FRM_BITS];

    // Out-of-range warps only exist in non-power-of-two configurations.
    assign fpu_read_frm = ({1'b0, fpu_read_wid} < (NW_BITS+1)'(NUM_WARPS)) ? frm[fpu_read_wid] : '0;

    // Decode the request and form the old value, forwarding flags still in the pending stage.
    always_comb begin
        hit_ff       = (csr_req_addr == CSR_FFLAGS);
        hit_frm      = (csr_req_addr == CSR_FRM);
        hit_fcsr     = (csr_req_addr == CSR_FCSR);
        wid_ok       = ({1'b0, csr_req_wid} < (NW_BITS+1)'(NUM_WARPS));
        supported    = wid_ok && (hit_ff || hit_frm || hit_fcsr);
        pend_hit_req = pend_valid && (pend_wid == csr_req_wid);
        pend_fwd     = pend_hit_req ? pend_fflags : '0;
        cur_frm      = frm[csr_req_wid];
        eff_fflags   = fflags[csr_req_wid] | pend_fwd;
        rd_data      = '0;
        if (supported) begin
            if (hit_ff)   rd_data = 32'(eff_fflags);
            if (hit_frm)  rd_data = 32'(cur_frm);
            if (hit_fcsr) rd_data = 32'({cur_frm, eff_fflags});
        end
        accept  = csr_req_valid && csr_req_ready;
        wr_fire = accept && csr_req_write && supported;
    end

    // Next state per warp: commit pending FPU flags, and let a CSR write override
    // while still keeping any in-flight FPU flags for the same warp.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            fflags_nxt[w] = fflags[w];
            frm_nxt[w]    = frm[w];
            if (pend_valid && (pend_wid == NW_BITS'(w)))
                fflags_nxt[w] = fflags[w] | pend_fflags;
            if (wr_fire && (csr_req_wid == NW_BITS'(w))) begin
                if (hit_ff || hit_fcsr)
                    fflags_nxt[w] = csr_req_wdata[FFLAGS_BITS-1:0] | pend_fwd;
                if (hit_frm)
                    frm_nxt[w] = csr_req_wdata[FRM_BITS-1:0];
                if (hit_fcsr)
                    frm_nxt[w] = csr_req_wdata[FFLAGS_BITS +: FRM_BITS];
            end
        end
    end

    // State registers and the one-stage FPU write-back pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags[w] <= '0;
                frm[w]    <= '0;
            end
            pend_valid  <= 1'b0;
            pend_wid    <= '0;
            pend_fflags <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags[w] <= fflags_nxt[w];
                frm[w]    <= frm_nxt[w];
            end
            pend_valid  <= fpu_write_enable;
            pend_wid    <= fpu_write_wid;
            pend_fflags <= fpu_write_enable ? fpu_write_fflags : '0;
        end
    end

    fpu_csr_rsp_buf #(
        .WIDTH(33)
    ) u_rsp_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (csr_req_valid),
        .in_ready  (csr_req_ready),
        .in_data   ({!supported, rd_data}),
        .out_valid (csr_rsp_valid),
        .out_ready (csr_rsp_ready),
        .out_data  ({csr_rsp_err, csr_rsp_data})
    );

endmodule

// File: tb/tb_fpu_csr_state.sv
// tb/tb_fpu_csr_state.sv - self-checking bench for fpu_csr_state
module tb_fpu_csr_state;
    import fpu_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fpu_write_enable;
    logic [1:0]  fpu_write_wid;
    logic [4:0]  fpu_write_fflags;
    logic [1:0]  fpu_read_wid;
    logic [2:0]  fpu_read_frm;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [1:0]  csr_req_wid;
    logic [11:0] csr_req_addr;
    logic        csr_req_write;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_data;
    logic        csr_rsp_err;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb[$];

    typedef struct {
        logic [1:0]  wid;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t tab_a[4];
    vec_t tab_b[17];

    always #5 clk = ~clk;

    fpu_csr_state dut (
        .clk              (clk),
        .reset            (reset),
        .fpu_write_enable (fpu_write_enable),
        .fpu_write_wid    (fpu_write_wid),
        .fpu_write_fflags (fpu_write_fflags),
        .fpu_read_wid     (fpu_read_wid),
        .fpu_read_frm     (fpu_read_frm),
        .csr_req_valid    (csr_req_valid),
        .csr_req_ready    (csr_req_ready),
        .csr_req_wid      (csr_req_wid),
        .csr_req_addr     (csr_req_addr),
        .csr_req_write    (csr_req_write),
        .csr_req_wdata    (csr_req_wdata),
        .csr_rsp_valid    (csr_rsp_valid),
        .csr_rsp_ready    (csr_rsp_ready),
        .csr_rsp_data     (csr_rsp_data),
        .csr_rsp_err      (csr_rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (reset && csr_rsp_valid && csr_rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {csr_rsp_err, csr_rsp_data}, 33'h1_dead_beef);
            end else begin
                chk("rsp", {csr_rsp_err, csr_rsp_data}, sb.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic csr(input logic [1:0] wid, input logic [11:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] data,
                       output int waits);
        bit ok = 0;
        csr_req_valid = 1'b1;
        csr_req_wid   = wid;
        csr_req_addr  = addr;
        csr_req_write = wr;
        csr_req_wdata = wdata;
        sb.push_back({err, data});
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (csr_req_ready) begin
                ok = 1;
                break;
            end
            waits++;
        end
        if (!ok) chk("req_timeout", 0, 1);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
    endtask

    task automatic fpu_wr(input logic [1:0] wid, input logic [4:0] f);
        @(posedge clk);
        #1;
        fpu_write_enable = 1'b1;
        fpu_write_wid    = wid;
        fpu_write_fflags = f;
    endtask

    task automatic fpu_idle();
        @(posedge clk);
        #1;
        fpu_write_enable = 1'b0;
        fpu_write_fflags = '0;
    endtask

    initial begin
        int w_cnt;
        fflags_t ef;
        logic [2:0] exp_frm[4];

        tab_a[0] = '{2'd0, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h0};
        tab_a[1] = '{2'd1, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h0};
        tab_a[2] = '{2'd2, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h0};
        tab_a[3] = '{2'd3, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h0};

        tab_b[0]  = '{2'd2, CSR_FFLAGS, 1'b0, 32'h0,        1'b0, 32'h11};
        tab_b[1]  = '{2'd0, CSR_FFLAGS, 1'b0, 32'h0,        1'b0, 32'h1D};
        tab_b[2]  = '{2'd1, CSR_FFLAGS, 1'b0, 32'h0,        1'b0, 32'h00};
        tab_b[3]  = '{2'd3, CSR_FFLAGS, 1'b0, 32'h0,        1'b0, 32'h00};
        tab_b[4]  = '{2'd1, CSR_FCSR,   1'b1, 32'hE5,       1'b0, 32'h00};
        tab_b[5]  = '{2'd1, CSR_FFLAGS, 1'b0, 32'h0,        1'b0, 32'h05};
        tab_b[6]  = '{2'd1, CSR_FRM,    1'b0, 32'h0,        1'b0, 32'h07};
        tab_b[7]  = '{2'd1, CSR_FCSR,   1'b0, 32'h0,        1'b0, 32'hE5};
        tab_b[8]  = '{2'd2, CSR_FRM,    1'b1, 32'hFFFFFFFD, 1'b0, 32'h00};
        tab_b[9]  = '{2'd2, CSR_FCSR,   1'b0, 32'h0,        1'b0, 32'hB1};
        tab_b[10] = '{2'd0, 12'h300,    1'b0, 32'h0,        1'b1, 32'h00};
        tab_b[11] = '{2'd2, 12'h300,    1'b1, 32'hFF,       1'b1, 32'h00};
        tab_b[12] = '{2'd2, CSR_FCSR,   1'b0, 32'h0,        1'b0, 32'hB1};
        tab_b[13] = '{2'd2, CSR_FFLAGS, 1'b1, 32'h0,        1'b0, 32'h11};
        tab_b[14] = '{2'd2, CSR_FCSR,   1'b0, 32'h0,        1'b0, 32'hA0};
        tab_b[15] = '{2'd1, 12'h004,    1'b0, 32'h0,        1'b1, 32'h00};
        tab_b[16] = '{2'd1, 12'h000,    1'b0, 32'h0,        1'b1, 32'h00};

        exp_frm[0] = 3'd0;
        exp_frm[1] = 3'd7;
        exp_frm[2] = 3'd5;
        exp_frm[3] = 3'd0;

        reset            = 1'b0;
        fpu_write_enable = 1'b0;
        fpu_write_wid    = '0;
        fpu_write_fflags = '0;
        fpu_read_wid     = '0;
        csr_req_valid    = 1'b0;
        csr_req_wid      = '0;
        csr_req_addr     = '0;
        csr_req_write    = 1'b0;
        csr_req_wdata    = '0;
        csr_rsp_ready    = 1'b1;
        #23;
        reset = 1'b1;
        chk("reset_rsp_valid", csr_rsp_valid, 0);
        chk("reset_req_ready", csr_req_ready, 1);
        chk("reset_read_frm", fpu_read_frm, 0);
        @(posedge clk);
        #1;

        foreach (tab_a[i])
            csr(tab_a[i].wid, tab_a[i].addr, tab_a[i].wr, tab_a[i].wdata, tab_a[i].err, tab_a[i].data, w_cnt);

        // Two back-to-back flag write-backs to warp 2, then a zero-flag write to warp 1.
        fpu_wr(2'd2, 5'b00001);
        fpu_wr(2'd2, 5'b10000);
        fpu_wr(2'd1, 5'b00000);
        fpu_idle();

        // Read while the write-back is still in the pending stage.
        fpu_wr(2'd0, 5'h04);
        @(posedge clk);
        #1;
        fpu_write_enable = 1'b0;
        csr(2'd0, CSR_FFLAGS, 1'b0, 32'h0, 1'b0, 32'h04, w_cnt);

        // Three consecutive write-backs to the same warp all accumulate.
        fpu_wr(2'd0, 5'h01);
        fpu_wr(2'd0, 5'h08);
        fpu_wr(2'd0, 5'h10);
        fpu_idle();
        @(posedge clk);
        #1;

        fpu_read_wid = 2'd1;
        chk("frm_w1_before", fpu_read_frm, 0);
        for (int i = 0; i < 17; i++) begin
            csr(tab_b[i].wid, tab_b[i].addr, tab_b[i].wr, tab_b[i].wdata, tab_b[i].err, tab_b[i].data, w_cnt);
            if (i == 4) chk("frm_w1_next_cycle", fpu_read_frm, 3'b111);
        end
        for (int w = 0; w < 4; w++) begin
            fpu_read_wid = 2'(w);
            #1;
            chk($sformatf("read_frm_w%0d", w), fpu_read_frm, exp_frm[w]);
        end

        // CSR fflags write colliding with a pending write-back to the same warp.
        fpu_wr(2'd3, 5'h02);
        @(posedge clk);
        #1;
        fpu_write_enable = 1'b0;
        csr(2'd3, CSR_FFLAGS, 1'b1, 32'h08, 1'b0, 32'h02, w_cnt);
        ef = '{nv: 1'b0, dz: 1'b1, of: 1'b0, uf: 1'b1, nx: 1'b0};
        csr(2'd3, CSR_FFLAGS, 1'b0, 32'h0, 1'b0, 32'(ef), w_cnt);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: one held response, a second request waits until ready rises.
        csr_rsp_ready = 1'b0;
        csr(2'd3, CSR_FFLAGS, 1'b0, 32'h0, 1'b0, 32'h0A, w_cnt);
        fork
            begin
                csr(2'd1, CSR_FRM, 1'b0, 32'h0, 1'b0, 32'h07, w_cnt);
                chk("bp_wait_cycles", w_cnt, 3);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_req_ready", csr_req_ready, 0);
                    chk("bp_rsp_valid", csr_rsp_valid, 1);
                    chk("bp_rsp_data", csr_rsp_data, 32'h0A);
                end
                @(posedge clk);
                #1;
                csr_rsp_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset while a response is held and a write-back is pending.
        csr_rsp_ready = 1'b0;
        fpu_wr(2'd3, 5'h1F);
        csr(2'd2, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'hA0, w_cnt);
        fpu_write_enable = 1'b0;
        chk("held_rsp_valid", csr_rsp_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_drop_valid", csr_rsp_valid, 0);
        chk("rst_drop_data", csr_rsp_data, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        csr_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        csr(2'd3, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h00, w_cnt);
        csr(2'd1, CSR_FCSR, 1'b0, 32'h0, 1'b0, 32'h00, w_cnt);
        fpu_read_wid = 2'd1;
        #1;
        chk("rst_frm_w1", fpu_read_frm, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
